branch_resolve_unit: RTL and testbench

- EX-stage resolution end of the history predictor interface: tracks each IF-stage direction prediction through ID and EX.
- Compares each prediction against the actual branch outcome computed in EX.
- Produces the predictor training and rollback controls, plus the pipeline flush/redirect.
- Keeps saturating branch/mispredict statistics.

---
 rtl/branch_resolve_unit.sv | 131 +++++++++++++
 tb/tb_branch_resolve_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: carries each IF direction prediction through ID/EX,
// compares it with the EX outcome, and drives predictor training/rollback, flush/redirect and stats.
module branch_resolve_unit #(
  parameter int RECOVER_CYCLES = 2,
  parameter int STAT_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pl_stall,
  input  logic                  pred_valid_if,
  input  logic                  pred_taken_if,
  input  logic [31:0]           pred_target_if,
  input  logic                  br_valid_ex,
  input  logic                  br_taken_ex,
  input  logic [31:0]           br_target_ex,
  input  logic [31:0]           pc_ex,
  output logic                  corrected_en,
  output logic                  corrected_result,
  output logic                  rollback_en_ex,
  output logic                  rollback_en_id,
  output logic                  prediction_result_branch_failed,
  output logic                  flush,
  output logic                  redirect_en,
  output logic [31:0]           redirect_pc,
  output logic [STAT_WIDTH-1:0] branch_cnt,
  output logic [STAT_WIDTH-1:0] miss_cnt
);

  localparam int CNT_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;

  typedef enum logic {RUN, RECOVER} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    id_vld_q, id_vld_d, ex_vld_q, ex_vld_d;
  logic                    id_taken_q, id_taken_d, ex_taken_q, ex_taken_d;
  logic [31:0]             id_target_q, id_target_d, ex_target_q, ex_target_d;
  logic [STAT_WIDTH-1:0]   branch_cnt_q, branch_cnt_d, miss_cnt_q, miss_cnt_d;
  logic                    resolve, mispredict, pred_taken;

  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v,
                                                    input logic                  en);
    if (en && (v != {STAT_WIDTH{1'b1}}))
      return v + 1'b1;
    return v;
  endfunction

  always_comb begin
    resolve    = rst_n && br_valid_ex && !pl_stall && (state_q == RUN);
    // An empty EX slot behaves as a not-taken prediction.
    pred_taken = ex_vld_q && ex_taken_q;
    mispredict = resolve && ((pred_taken != br_taken_ex) ||
                             (pred_taken && br_taken_ex && (ex_target_q != br_target_ex)));

    corrected_en                    = resolve && !mispredict;
    corrected_result                = br_taken_ex;
    rollback_en_ex                  = mispredict;
    rollback_en_id                  = mispredict && id_vld_q;
    prediction_result_branch_failed = mispredict && pred_taken;
    flush                           = mispredict;
    redirect_en                     = mispredict;
    redirect_pc                     = mispredict ? (br_taken_ex ? br_target_ex : pc_ex + 32'd4)
                                                 : 32'd0;
  end

  always_comb begin
    id_vld_d     = id_vld_q;
    id_taken_d   = id_taken_q;
    id_target_d  = id_target_q;
    ex_vld_d     = ex_vld_q;
    ex_taken_d   = ex_taken_q;
    ex_target_d  = ex_target_q;
    state_d      = state_q;
    cnt_d        = cnt_q;
    branch_cnt_d = sat_inc(branch_cnt_q, resolve);
    miss_cnt_d   = sat_inc(miss_cnt_q, mispredict);

    if (!pl_stall) begin
      ex_vld_d    = id_vld_q;
      ex_taken_d  = id_taken_q;
      ex_target_d = id_target_q;
      id_vld_d    = pred_valid_if && (state_q == RUN);
      id_taken_d  = pred_taken_if;
      id_target_d = pred_target_if;
      if (mispredict) begin
        id_vld_d = 1'b0;
        ex_vld_d = 1'b0;
      end
    end

    if (mispredict) begin
      state_d = RECOVER;
      cnt_d   = CNT_W'(RECOVER_CYCLES - 1);
    end else if (state_q == RECOVER && !pl_stall) begin
      if (cnt_q == '0)
        state_d = RUN;
      else
        cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= RUN;
      cnt_q        <= '0;
      id_vld_q     <= 1'b0;
      ex_vld_q     <= 1'b0;
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      id_vld_q     <= id_vld_d;
      ex_vld_q     <= ex_vld_d;
      branch_cnt_q <= branch_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  // Slot payload is qualified by the valid bits, so it carries no reset.
  always_ff @(posedge clk) begin
    id_taken_q  <= id_taken_d;
    id_target_q <= id_target_d;
    ex_taken_q  <= ex_taken_d;
    ex_target_q <= ex_target_d;
  end

  assign branch_cnt = branch_cnt_q;
  assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit (STAT_WIDTH=4 build so saturation is reachable).
module tb_branch_resolve_unit;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst_n, pl_stall;
  logic          pred_valid_if, pred_taken_if;
  logic [31:0]   pred_target_if;
  logic          br_valid_ex, br_taken_ex;
  logic [31:0]   br_target_ex, pc_ex;
  logic          corrected_en, corrected_result, rollback_en_ex, rollback_en_id;
  logic          prediction_result_branch_failed, flush, redirect_en;
  logic [31:0]   redirect_pc;
  logic [SW-1:0] branch_cnt, miss_cnt;

  int n_chk = 0;
  int n_err = 0;

  branch_resolve_unit #(.RECOVER_CYCLES(2), .STAT_WIDTH(SW)) dut (
    .clk(clk), .rst_n(rst_n), .pl_stall(pl_stall),
    .pred_valid_if(pred_valid_if), .pred_taken_if(pred_taken_if), .pred_target_if(pred_target_if),
    .br_valid_ex(br_valid_ex), .br_taken_ex(br_taken_ex), .br_target_ex(br_target_ex), .pc_ex(pc_ex),
    .corrected_en(corrected_en), .corrected_result(corrected_result),
    .rollback_en_ex(rollback_en_ex), .rollback_en_id(rollback_en_id),
    .prediction_result_branch_failed(prediction_result_branch_failed),
    .flush(flush), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .branch_cnt(branch_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pred(input logic v, input logic t, input logic [31:0] tgt);
    pred_valid_if = v; pred_taken_if = t; pred_target_if = tgt;
  endtask

  task automatic br(input logic v, input logic t, input logic [31:0] tgt, input logic [31:0] pc);
    br_valid_ex = v; br_taken_ex = t; br_target_ex = tgt; pc_ex = pc;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_corr"}, {31'd0, corrected_en}, 32'd0);
    chk({tag, "_rbex"}, {31'd0, rollback_en_ex}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; pl_stall = 1'b0;
    pred(0, 0, 0); br(0, 0, 0, 0);
    tick(); tick();
    br(1, 1, 32'h10, 32'h0);
    #1;
    chk_quiet("rst_strobes");
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_rpc", redirect_pc, 32'd0);
    chk("rst_bcnt", 32'(branch_cnt), 32'd0);
    chk("rst_mcnt", 32'(miss_cnt), 32'd0);
    br(0, 0, 0, 0);
    rst_n = 1'b1;
    tick();

    // Correct taken prediction
    pred(1, 1, 32'h100); tick();
    pred(0, 0, 0);       tick();
    br(1, 1, 32'h100, 32'h40); #1;
    chk("t1_corr", {31'd0, corrected_en}, 32'd1);
    chk("t1_res", {31'd0, corrected_result}, 32'd1);
    chk("t1_rbex", {31'd0, rollback_en_ex}, 32'd0);
    chk("t1_flush", {31'd0, flush}, 32'd0);
    tick(); br(0, 0, 0, 0);
    chk("t1_bcnt", 32'(branch_cnt), 32'd1);
    chk("t1_mcnt", 32'(miss_cnt), 32'd0);

    // Predicted taken, actually not taken, second prediction sitting in ID
    pred(1, 1, 32'h500); tick();
    pred(1, 0, 32'h0);   tick();
    br(1, 0, 32'h0, 32'h80); pred(1, 1, 32'h600); #1;
    chk("t2_rbex", {31'd0, rollback_en_ex}, 32'd1);
    chk("t2_rbid", {31'd0, rollback_en_id}, 32'd1);
    chk("t2_fail", {31'd0, prediction_result_branch_failed}, 32'd1);
    chk("t2_flush", {31'd0, flush}, 32'd1);
    chk("t2_redir", {31'd0, redirect_en}, 32'd1);
    chk("t2_rpc", redirect_pc, 32'h84);
    chk("t2_corr", {31'd0, corrected_en}, 32'd0);
    tick();
    br(1, 1, 32'h999, 32'h90); #1;
    chk_quiet("t2_rec1");
    tick(); #1;
    chk_quiet("t2_rec2");
    tick();
    chk("t2_bcnt", 32'(branch_cnt), 32'd2);
    chk("t2_mcnt", 32'(miss_cnt), 32'd1);

    // Back in RUN with both slots empty: actual taken is a mispredict, not a failed taken
    pred(0, 0, 0); br(1, 1, 32'h200, 32'h1000); #1;
    chk("t3_rbex", {31'd0, rollback_en_ex}, 32'd1);
    chk("t3_rbid", {31'd0, rollback_en_id}, 32'd0);
    chk("t3_fail", {31'd0, prediction_result_branch_failed}, 32'd0);
    chk("t3_rpc", redirect_pc, 32'h200);
    tick(); br(0, 0, 0, 0);
    chk("t3_mcnt", 32'(miss_cnt), 32'd2);
    tick(); tick();

    // Taken/taken with target mismatch
    pred(1, 1, 32'h300); tick();
    pred(0, 0, 0);       tick();
    br(1, 1, 32'h304, 32'h50); #1;
    chk("t4_rbex", {31'd0, rollback_en_ex}, 32'd1);
    chk("t4_corr", {31'd0, corrected_en}, 32'd0);
    chk("t4_fail", {31'd0, prediction_result_branch_failed}, 32'd1);
    chk("t4_rpc", redirect_pc, 32'h304);
    tick(); br(0, 0, 0, 0);
    tick(); tick();
    chk("t4_bcnt", 32'(branch_cnt), 32'd4);
    chk("t4_mcnt", 32'(miss_cnt), 32'd3);

    // Stall for 3 cycles with a resolving branch waiting in EX
    pred(1, 1, 32'h700); tick();
    pred(0, 0, 0);       tick();
    pl_stall = 1'b1; pred(1, 0, 32'h0); br(1, 1, 32'h700, 32'h60);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_quiet("t5_stall");
      tick();
    end
    pl_stall = 1'b0; pred(0, 0, 0); #1;
    chk("t5_corr", {31'd0, corrected_en}, 32'd1);
    chk("t5_rbex", {31'd0, rollback_en_ex}, 32'd0);
    tick(); br(0, 0, 0, 0); #1;
    chk("t5_once", {31'd0, corrected_en}, 32'd0);
    chk("t5_bcnt", 32'(branch_cnt), 32'd5);

    // Saturation: 18 more correct not-taken resolves with empty slots
    br(1, 0, 32'h0, 32'h70);
    for (int i = 0; i < 18; i++) tick();
    br(0, 0, 0, 0);
    chk("sat_bcnt", 32'(branch_cnt), 32'hF);
    chk("sat_mcnt", 32'(miss_cnt), 32'd3);

    // Reset in the middle of RECOVER
    br(1, 1, 32'h800, 32'h74); tick();
    br(0, 0, 0, 0); rst_n = 1'b0; tick();
    chk("rr_bcnt", 32'(branch_cnt), 32'd0);
    chk("rr_mcnt", 32'(miss_cnt), 32'd0);
    rst_n = 1'b1;
    br(1, 0, 32'h0, 32'h78); #1;
    chk("rr_run", {31'd0, corrected_en}, 32'd1);
    tick(); br(0, 0, 0, 0);
    chk("rr_bcnt2", 32'(branch_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
